// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: producer/consumer bundle for sync_fifo_flags.
//   master modport: the user side. It drives wr_en/wr_data/rd_en and observes
//                   the read data, status flags, occupancy and error pulses.
//   slave  modport: the FIFO side.
// Signals:
//   wr_en, wr_data      write request and word
//   rd_en, rd_data      read request (pop) and word
//   full, empty         occupancy at the limits
//   almost_full/empty   threshold flags
//   count               occupancy, 0..DEPTH
//   overflow/underflow  one-cycle pulses on rejected requests
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO of arbitrary depth with an occupancy
// count, programmable almost-full/almost-empty thresholds, overflow and
// underflow pulses, and a selectable first-word-fall-through read mode.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  sync_fifo_flags_if.slave (write/read handshakes, data, status)
// Parameters:
//   DATA_WIDTH  word width (>=1)
//   DEPTH       number of entries (>=2, any value)
//   AF_LEVEL    almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT        0 = registered read, 1 = head word shown on rd_data
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic               clk,
    input  logic               rst,
    sync_fifo_flags_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

    // Storage: no reset so it maps onto block/distributed RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, full_next;
    logic          empty_reg, empty_next;
    logic          af_reg, af_next;
    logic          ae_reg, ae_next;
    logic          overflow_reg;
    logic          underflow_reg;
    logic          wr_acc;
    logic          rd_acc;

    always_comb begin
        // Acceptance is judged on the registered flags, i.e. the state
        // before the edge; a read at full frees no space this cycle.
        wr_acc = bus.wr_en && !full_reg;
        rd_acc = bus.rd_en && !empty_reg;

        // Explicit wrap compare so non-power-of-two depths work.
        wr_ptr_next = wr_ptr_reg;
        if (wr_acc) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + AW'(1);
        end
        rd_ptr_next = rd_ptr_reg;
        if (rd_acc) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + AW'(1);
        end

        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

        // All status flags derive from the same next count so they are
        // registered together and never disagree with count.
        full_next  = (count_next == DEPTH_CNT);
        empty_next = (count_next == '0);
        af_next    = (count_next >= AF_CNT);
        ae_next    = (count_next <= AE_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            full_reg      <= 1'b0;
            empty_reg     <= 1'b1;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            full_reg      <= full_next;
            empty_reg     <= empty_next;
            af_reg        <= af_next;
            ae_reg        <= ae_next;
            overflow_reg  <= bus.wr_en && full_reg;
            underflow_reg <= bus.rd_en && empty_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; a write into an empty FIFO
            // lands at rd_ptr and is visible right after that edge.
            assign bus.rd_data = mem[rd_ptr_reg];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_reg <= '0;
                end else if (rd_acc) begin
                    rd_data_reg <= mem[rd_ptr_reg];
                end
            end

            assign bus.rd_data = rd_data_reg;
        end
    endgenerate

    assign bus.count        = count_reg;
    assign bus.full         = full_reg;
    assign bus.empty        = empty_reg;
    assign bus.almost_full  = af_reg;
    assign bus.almost_empty = ae_reg;
    assign bus.overflow     = overflow_reg;
    assign bus.underflow    = underflow_reg;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Testbench for sync_fifo_flags. Three instances:
//   a: DEPTH=16, AF=14, AE=2, standard read
//   b: DEPTH=5,  AF=4,  AE=1, standard read
//   c: DEPTH=16, FWFT read
// Expected read words are pushed into per-instance queues as reads are
// issued; monitors pop and compare when the DUT presents read data.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) bus_a ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(5))  bus_b ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) bus_c ();

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] exp_c[$];

    logic rd_expect_a = 1'b0, rd_chk_a = 1'b0;
    logic rd_expect_b = 1'b0, rd_chk_b = 1'b0;
    logic rd_expect_c = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int c);
        chk({tag, ".a.count"}, 32'(bus_a.count), 32'(c));
        chk({tag, ".a.full"},  32'(bus_a.full),  32'(c == 16));
        chk({tag, ".a.empty"}, 32'(bus_a.empty), 32'(c == 0));
        chk({tag, ".a.af"},    32'(bus_a.almost_full),  32'(c >= 14));
        chk({tag, ".a.ae"},    32'(bus_a.almost_empty), 32'(c <= 2));
    endtask

    task automatic chk_b(input string tag, input int c);
        chk({tag, ".b.count"}, 32'(bus_b.count), 32'(c));
        chk({tag, ".b.full"},  32'(bus_b.full),  32'(c == 5));
        chk({tag, ".b.empty"}, 32'(bus_b.empty), 32'(c == 0));
        chk({tag, ".b.af"},    32'(bus_b.almost_full),  32'(c >= 4));
        chk({tag, ".b.ae"},    32'(bus_b.almost_empty), 32'(c <= 1));
    endtask

    // Standard mode: data is valid the cycle after the accepted read.
    always @(posedge clk) begin
        rd_chk_a <= rd_expect_a;
        rd_chk_b <= rd_expect_b;
    end

    always @(negedge clk) begin
        if (rd_chk_a) begin
            if (exp_a.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL a.rd_data: got 0x%02h, want none queued", bus_a.rd_data);
            end else begin
                logic [7:0] e;
                e = exp_a.pop_front();
                $display("[%0t] a read 0x%02h expect 0x%02h", $time, bus_a.rd_data, e);
                chk("a.rd_data", 32'(bus_a.rd_data), 32'(e));
            end
        end
        if (rd_chk_b) begin
            if (exp_b.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL b.rd_data: got 0x%02h, want none queued", bus_b.rd_data);
            end else begin
                logic [7:0] e;
                e = exp_b.pop_front();
                $display("[%0t] b read 0x%02h expect 0x%02h", $time, bus_b.rd_data, e);
                chk("b.rd_data", 32'(bus_b.rd_data), 32'(e));
            end
        end
    end

    // FWFT mode: data is valid in the same cycle rd_en is asserted.
    always @(negedge clk) begin
        #2;
        if (rd_expect_c) begin
            if (exp_c.size() == 0) begin
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL c.rd_data: got 0x%02h, want none queued", bus_c.rd_data);
            end else begin
                logic [7:0] e;
                e = exp_c.pop_front();
                $display("[%0t] c read 0x%02h expect 0x%02h", $time, bus_c.rd_data, e);
                chk("c.rd_data", 32'(bus_c.rd_data), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.wr_en = 0; bus_a.rd_en = 0; bus_a.wr_data = 0;
        bus_b.wr_en = 0; bus_b.rd_en = 0; bus_b.wr_data = 0;
        bus_c.wr_en = 0; bus_c.rd_en = 0; bus_c.wr_data = 0;

        // ---------------- reset state ----------------
        #12;
        chk_a("rst", 0);
        chk("rst.a.ov", 32'(bus_a.overflow), 0);
        chk("rst.a.un", 32'(bus_a.underflow), 0);
        chk("rst.a.rd_data", 32'(bus_a.rd_data), 0);
        chk_b("rst", 0);
        chk("rst.c.empty", 32'(bus_c.empty), 1);
        @(negedge clk);
        rst = 0;

        // ---------------- fill 0x00..0x0F ----------------
        for (int i = 0; i < 16; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(i);
            @(negedge clk);
            chk_a($sformatf("fill%0d", i), i + 1);
        end

        // ---------------- overflow ----------------
        bus_a.wr_data = 8'hAA;
        @(negedge clk);
        bus_a.wr_en = 0;
        chk("ovf.pulse", 32'(bus_a.overflow), 1);
        chk_a("ovf", 16);
        @(negedge clk);
        chk("ovf.clear", 32'(bus_a.overflow), 0);
        chk_a("ovf2", 16);

        // ---------------- drain ----------------
        for (int i = 0; i < 16; i++) begin
            bus_a.rd_en = 1; rd_expect_a = 1; exp_a.push_back(8'(i));
            @(negedge clk);
            chk_a($sformatf("drain%0d", i), 15 - i);
        end
        bus_a.rd_en = 0; rd_expect_a = 0;

        // ---------------- underflow ----------------
        bus_a.rd_en = 1;
        @(negedge clk);
        bus_a.rd_en = 0;
        chk("unf.pulse", 32'(bus_a.underflow), 1);
        chk_a("unf", 0);
        chk("unf.hold", 32'(bus_a.rd_data), 32'h0F);
        @(negedge clk);
        chk("unf.clear", 32'(bus_a.underflow), 0);

        // ---------------- simultaneous at count 5, across wrap ----------------
        for (int i = 0; i < 5; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h10 + i);
            @(negedge clk);
        end
        chk_a("sim.pre", 5);
        for (int i = 0; i < 20; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h15 + i);
            bus_a.rd_en = 1; rd_expect_a = 1; exp_a.push_back(8'(8'h10 + i));
            @(negedge clk);
            chk_a($sformatf("sim%0d", i), 5);
        end
        bus_a.wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            bus_a.rd_en = 1; rd_expect_a = 1; exp_a.push_back(8'(8'h24 + i));
            @(negedge clk);
            chk_a($sformatf("simdr%0d", i), 4 - i);
        end
        bus_a.rd_en = 0; rd_expect_a = 0;

        // ---------------- both requests while full ----------------
        for (int i = 0; i < 16; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h30 + i);
            @(negedge clk);
        end
        chk_a("fb.pre", 16);
        bus_a.wr_en = 1; bus_a.wr_data = 8'hEE;
        bus_a.rd_en = 1; rd_expect_a = 1; exp_a.push_back(8'h30);
        @(negedge clk);
        bus_a.wr_en = 0;
        chk("fb.ovf", 32'(bus_a.overflow), 1);
        chk_a("fb", 15);
        for (int i = 0; i < 15; i++) begin
            bus_a.rd_en = 1; rd_expect_a = 1; exp_a.push_back(8'(8'h31 + i));
            @(negedge clk);
            chk_a($sformatf("fbdr%0d", i), 14 - i);
        end
        bus_a.rd_en = 0; rd_expect_a = 0;

        // ---------------- DEPTH=5 ----------------
        for (int v = 1; v <= 5; v++) begin
            bus_b.wr_en = 1; bus_b.wr_data = 8'(v);
            @(negedge clk);
            chk_b($sformatf("b.w%0d", v), v);
        end
        bus_b.wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            bus_b.rd_en = 1; rd_expect_b = 1; exp_b.push_back(8'(i + 1));
            @(negedge clk);
            chk_b($sformatf("b.r%0d", i), 4 - i);
        end
        bus_b.rd_en = 0; rd_expect_b = 0;
        for (int v = 6; v <= 8; v++) begin
            bus_b.wr_en = 1; bus_b.wr_data = 8'(v);
            @(negedge clk);
            chk_b($sformatf("b.w%0d", v), v - 3);
        end
        bus_b.wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            bus_b.rd_en = 1; rd_expect_b = 1; exp_b.push_back(8'(i + 4));
            @(negedge clk);
            chk_b($sformatf("b.d%0d", i), 4 - i);
        end
        bus_b.rd_en = 0; rd_expect_b = 0;

        // ---------------- FWFT ----------------
        bus_c.wr_en = 1; bus_c.wr_data = 8'h3C;
        @(negedge clk);
        bus_c.wr_en = 0;
        chk("c.head3C", 32'(bus_c.rd_data), 32'h3C);
        chk("c.empty1", 32'(bus_c.empty), 0);
        chk("c.count1", 32'(bus_c.count), 1);
        bus_c.rd_en = 1; rd_expect_c = 1; exp_c.push_back(8'h3C);
        @(negedge clk);
        bus_c.rd_en = 0; rd_expect_c = 0;
        chk("c.empty0", 32'(bus_c.empty), 1);
        chk("c.count0", 32'(bus_c.count), 0);
        bus_c.wr_en = 1; bus_c.wr_data = 8'h3D;
        @(negedge clk);
        bus_c.wr_data = 8'hA1;
        chk("c.head3D", 32'(bus_c.rd_data), 32'h3D);
        chk("c.empty2", 32'(bus_c.empty), 0);
        @(negedge clk);
        bus_c.wr_data = 8'hA2;
        @(negedge clk);
        bus_c.wr_en = 0;
        chk("c.count3", 32'(bus_c.count), 3);
        exp_c.push_back(8'h3D); exp_c.push_back(8'hA1); exp_c.push_back(8'hA2);
        bus_c.rd_en = 1; rd_expect_c = 1;
        repeat (3) @(negedge clk);
        bus_c.rd_en = 0; rd_expect_c = 0;
        chk("c.emptyend", 32'(bus_c.empty), 1);

        // ---------------- async reset mid-burst ----------------
        for (int i = 0; i < 9; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h50 + i);
            @(negedge clk);
        end
        chk_a("ar.pre", 9);
        bus_a.wr_data = 8'h77;
        #2 rst = 1;
        #1;
        chk_a("ar.async", 0);
        chk("ar.ov", 32'(bus_a.overflow), 0);
        chk("ar.rd_data", 32'(bus_a.rd_data), 0);
        @(negedge clk);
        chk_a("ar.held", 0);
        bus_a.wr_en = 0;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            bus_a.wr_en = 1; bus_a.wr_data = 8'(8'h60 + i);
            @(negedge clk);
            chk_a($sformatf("ar.w%0d", i), i + 1);
        end
        bus_a.wr_en = 0;
        for (int i = 0; i < 3; i++) begin
            bus_a.rd_en = 1; rd_expect_a = 1; exp_a.push_back(8'(8'h60 + i));
            @(negedge clk);
        end
        bus_a.rd_en = 0; rd_expect_a = 0;
        chk_a("ar.end", 0);

        repeat (2) @(negedge clk);
        #3;
        chk("a.q_left", 32'(exp_a.size()), 0);
        chk("b.q_left", 32'(exp_b.size()), 0);
        chk("c.q_left", 32'(exp_c.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO: the next generation of the team's synchronous buffer. Adds data ports, arbitrary depth (not restricted to powers of two), an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses and a selectable first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in the same clock domain wherever the datapath needs elastic buffering with back-pressure.

## Interface
- DATA_WIDTH, 8: width of each stored word; must be ≥1.
- DEPTH, 16: number of storage entries; any value ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard mode (registered read); 1 = first-word-fall-through.
- Derived: AW = max(1, clog2(DEPTH)); CW = clog2(DEPTH+1).

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write request.
- wr_data, input, DATA_WIDTH: write word.
- rd_en, input, 1: read request (pop).
- rd_data, output, DATA_WIDTH: read word.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count ≥ AF_LEVEL.
- almost_empty, output, 1: count ≤ AE_LEVEL.
- count, output, CW: current occupancy, 0..DEPTH.
- overflow, output, 1: one-cycle pulse on a rejected write.
- underflow, output, 1: one-cycle pulse on a rejected read.

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Both are judged on the flag values present before the edge.
- An accepted write stores wr_data at wr_ptr. An accepted read advances rd_ptr.
- Pointers are AW bits wide and wrap from DEPTH-1 to 0. The wrap is an explicit compare, not a natural overflow, so non-power-of-two DEPTH works.
- count update: write only → +1; read only → -1; both or neither → unchanged.
- Boundary cases for simultaneous requests:
  - Full with wr_en and rd_en: only the read is accepted, count goes to DEPTH-1, overflow pulses.
  - Empty with wr_en and rd_en: only the write is accepted, count goes to 1, underflow pulses.
- full, empty, almost_full, almost_empty and count are registers computed from the next count. All five are always mutually consistent in the same cycle.
- overflow = registered (wr_en && full); underflow = registered (rd_en && empty).
- Standard mode (FWFT=0): rd_data is a register loaded with mem[rd_ptr] on an accepted read. It holds its value otherwise.
- FWFT mode (FWFT=1): rd_data continuously presents mem[rd_ptr], the head word, whenever !empty. rd_en acknowledges and pops the head. rd_data is don't-care while empty.
- Memory contents are not reset.
- Reset (async assert, any time, including mid-burst): pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0 (AF_LEVEL ≥ 1), overflow 0, underflow 0, rd_data 0 in standard mode. Any in-flight request is dropped. Operation resumes on the first rising edge after rst deasserts.

## Timing
- Write at edge N:
  - Flags and count reflect the write after edge N.
  - In FWFT mode the word is visible on rd_data after edge N when the FIFO was empty (1-cycle write-to-read latency).
- Standard read: rd_en sampled at edge N → rd_data valid after edge N, i.e. on the cycle following the request.
- FWFT read: rd_data valid in the same cycle rd_en is asserted. The next head appears after the edge.
- Flag and pulse latency: the error pulses appear the cycle after the offending request; the flags follow the same rule as count.
- Throughput: one write and one read per cycle, sustained, with no bubbles at wrap-around.

## Test plan
- Reset/fill/drain (DEPTH=16, FWFT=0):
  - After reset, empty=1, almost_empty=1, full=0, count=0.
  - Write 0x00..0x0F on 16 consecutive cycles → count=16, full=1, almost_full asserted from count 14.
  - Read 16 → rd_data 0x00..0x0F in order, each one cycle after rd_en; empty=1 at end.
- Overflow/underflow:
  - When full, wr_en with 0xAA → overflow pulses exactly 1 cycle, count stays 16, 0xAA never read.
  - When empty, rd_en → underflow pulses exactly 1 cycle, count stays 0.
- Simultaneous read and write:
  - At count=5 with both asserted for 20 cycles → count stays 5, data order preserved across pointer wrap.
  - Both asserted at full → count 15, overflow=1.
- Non-power-of-two depth (DEPTH=5, AF=4, AE=1): write 1..5, read 3, write 6..8 → reads return 4,5,6,7,8. Confirms wrap at 5 and flags at each count.
- FWFT (FWFT=1):
  - Write 0x3C into an empty FIFO → rd_data=0x3C and empty=0 the next cycle, with no rd_en.
  - rd_en pops it; the next written word 0x3D appears immediately.
- Async reset mid-burst: assert rst between edges at count=9 → all flags and count reach reset values without waiting for a clock edge. Subsequent writes start at address 0 and read back correctly.
